// File: rtl/instr_reg_arbiter.sv
// instr_reg_arbiter
//   Write-side arbiter and pointer sequencer for the 32-entry instruction
//   register. N_REQ requesters share the single write port through a
//   round-robin grant. Accepted writes go to sequential slots. read_pointer
//   follows allocation order, so the register acts as an in-order queue.
//   The head entry is offered to one consumer through a valid/ready handshake.
//
//   Optional feature macro: IRA_STATS_EN (adds grant_cnt / stall_cnt).
//
// Ports
//   clk, reset                   clock; synchronous active-high reset
//   req_valid/req_ready          per-requester handshake (req_ready one-hot)
//   req_opcode/req_op_a/req_op_b per-requester instruction fields
//   load_en, write_pointer,      register write strobe, slot and data
//   opcode, operand_a, operand_b
//   read_pointer                 head slot address
//   instruction_word             register read data at read_pointer
//   out_valid/out_ready/out_word head-of-queue handshake and data
//   count                        committed entries (0..32)
//   grant_cnt, stall_cnt         saturating statistics (IRA_STATS_EN only)
module instr_reg_arbiter #(
    parameter int N_REQ = 2,
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0][3:0]   req_opcode,
    input  logic [N_REQ-1:0][31:0]  req_op_a,
    input  logic [N_REQ-1:0][31:0]  req_op_b,
    output logic                    load_en,
    output logic [4:0]              write_pointer,
    output logic [3:0]              opcode,
    output logic signed [31:0]      operand_a,
    output logic signed [31:0]      operand_b,
    output logic [4:0]              read_pointer,
    input  logic [67:0]             instruction_word,
    output logic                    out_valid,
    output logic [67:0]             out_word,
    input  logic                    out_ready,
    output logic [5:0]              count
`ifdef IRA_STATS_EN
    ,
    output logic [N_REQ-1:0][15:0]  grant_cnt,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int RR_W = (N_REQ > 2) ? 2 : 1;

    logic [RR_W-1:0]  rr_ptr;
    logic [RR_W-1:0]  gidx;
    logic [RR_W-1:0]  cand;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic             transfer;
    logic             full;
    logic             pop;
    logic [5:0]       alloc_count;
    logic [4:0]       wr_slot;

    // alloc_count includes writes still in the pipeline, so full blocks
    // grants before the committed count reaches DEPTH.
    assign full      = (alloc_count == 6'(DEPTH));
    assign out_valid = (count != 6'd0);
    assign pop       = out_valid & out_ready;
    assign out_word  = instruction_word;
    assign req_ready = grant;
    assign transfer  = |grant;

    // Round-robin search starting at rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        if (!full) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = RR_W'((32'(rr_ptr) + k) % N_REQ);
                if (!found && req_valid[cand]) begin
                    grant[cand] = 1'b1;
                    gidx        = cand;
                    found       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            load_en       <= 1'b0;
            write_pointer <= '0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
            wr_slot       <= '0;
            read_pointer  <= '0;
            alloc_count   <= '0;
            count         <= '0;
        end else begin
            load_en <= transfer;
            if (transfer) begin
                opcode        <= req_opcode[gidx];
                operand_a     <= req_op_a[gidx];
                operand_b     <= req_op_b[gidx];
                write_pointer <= wr_slot;
                wr_slot       <= wr_slot + 5'd1;
                rr_ptr        <= (gidx == RR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            if (pop) begin
                read_pointer <= read_pointer + 5'd1;
            end
            case ({transfer, pop})
                2'b10:   alloc_count <= alloc_count + 6'd1;
                2'b01:   alloc_count <= alloc_count - 6'd1;
                default: alloc_count <= alloc_count;
            endcase
            // Entry becomes committed the cycle after its write strobe.
            case ({load_en, pop})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef IRA_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant[i] && grant_cnt[i] != 16'hFFFF) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
            if ((|req_valid) && full && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
